// File: rtl/xy_zone_tracker_if.sv
// Point/zone bus between the position path and the zone tracker.
// master: drives the sampled point and strobe, observes the zone display.
// slave:  receives the point, drives the registered zone display.
interface xy_zone_tracker_if #(
  parameter int COORD_W = 11
);

  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               valid;
  logic [4:0]         leds;
  logic               tracking;

  modport master (
    output x,
    output y,
    output valid,
    input  leds,
    input  tracking
  );

  modport slave (
    input  x,
    input  y,
    input  valid,
    output leds,
    output tracking
  );

endinterface

// File: rtl/xy_zone_tracker.sv
// xy_zone_tracker: registered XY-to-LED zone indicator with per-edge
// hysteresis, N-sample debounce and loss-of-tracking timeout.
// LED layout: 1 = up, 4 = left, 0 = centre, 2 = right, 3 = down.
// Optional feature macro: XY_ZONE_TRACKER_LOST_BLINK_EN -- when defined, the
// centre LED blinks (half-period 2^BLINK_LOG2 cycles) while tracking is lost
// after at least one sample has been seen since reset.
module xy_zone_tracker #(
  parameter int COORD_W     = 11,
  parameter int MID_X       = 500,
  parameter int MID_Y       = 500,
  parameter int CENT_D      = 250,
  parameter int HYST        = 16,
  parameter int DEBOUNCE_N  = 3,
  parameter int LOST_CYCLES = 1000000,
  parameter int BLINK_LOG2  = 22
) (
  input  logic             clk,
  input  logic             reset,
  xy_zone_tracker_if.slave bus
);

  // Threshold arithmetic width: two guard bits keep MID +/- CENT_D signed-safe.
  localparam int unsigned TW     = COORD_W + 2;
  localparam int unsigned C_W    = $clog2(DEBOUNCE_N + 1);
  localparam int unsigned LC_W   = $clog2(LOST_CYCLES);

  // Edge flag bit positions in E / P / cand: {R, L, U, D}.
  localparam int unsigned ER = 3;
  localparam int unsigned EL = 2;
  localparam int unsigned EU = 1;
  localparam int unsigned ED = 0;

  // Enter thresholds (edge currently off) and hold thresholds (edge on).
  localparam logic signed [TW-1:0] R_ENTER = TW'(MID_X + CENT_D);
  localparam logic signed [TW-1:0] R_HOLD  = TW'(MID_X + CENT_D - HYST);
  localparam logic signed [TW-1:0] L_ENTER = TW'(MID_X - CENT_D);
  localparam logic signed [TW-1:0] L_HOLD  = TW'(MID_X - CENT_D + HYST);
  localparam logic signed [TW-1:0] U_ENTER = TW'(MID_Y + CENT_D);
  localparam logic signed [TW-1:0] U_HOLD  = TW'(MID_Y + CENT_D - HYST);
  localparam logic signed [TW-1:0] D_ENTER = TW'(MID_Y - CENT_D);
  localparam logic signed [TW-1:0] D_HOLD  = TW'(MID_Y - CENT_D + HYST);

  localparam logic [LC_W-1:0] LC_MAX  = LC_W'(LOST_CYCLES - 1);
  // Counter value at which the next empty cycle brings LC to LOST_CYCLES-1.
  localparam logic [LC_W-1:0] LC_LOSE = LC_W'(LOST_CYCLES - 2);
  localparam logic [C_W-1:0]  C_LAST  = C_W'(DEBOUNCE_N - 1);

  // Elaboration-time guard against unusable parameter sets.
  generate
    if (HYST < 0 || HYST >= CENT_D || DEBOUNCE_N < 1 || LOST_CYCLES < 2 ||
        BLINK_LOG2 < 1 || MID_X < CENT_D || MID_Y < CENT_D ||
        MID_X + CENT_D > (1 << COORD_W) - 1 ||
        MID_Y + CENT_D > (1 << COORD_W) - 1) begin : g_param_check
      $error("xy_zone_tracker: illegal parameter combination");
    end
  endgenerate

  logic [3:0]      e_q, e_d;
  logic [3:0]      p_q, p_d;
  logic [C_W-1:0]  c_q, c_d;
  logic [LC_W-1:0] lc_q, lc_d;
  logic            tracking_q, tracking_d;
  logic [4:0]      leds_q, leds_d;

`ifdef XY_ZONE_TRACKER_LOST_BLINK_EN
  localparam int unsigned BLINK_W = BLINK_LOG2 + 1;
  logic [BLINK_W-1:0] blink_q, blink_d;
  logic               seen_q, seen_d;
`endif

  logic signed [TW-1:0] x_s;
  logic signed [TW-1:0] y_s;
  logic [3:0]           cand_c;

  assign x_s = $signed(TW'(bus.x));
  assign y_s = $signed(TW'(bus.y));

  // Candidate edge flags: a lit edge uses the relaxed hold threshold.
  always_comb begin
    cand_c     = '0;
    cand_c[ER] = e_q[ER] ? (x_s > R_HOLD) : (x_s > R_ENTER);
    cand_c[EL] = e_q[EL] ? (x_s < L_HOLD) : (x_s < L_ENTER);
    cand_c[EU] = e_q[EU] ? (y_s > U_HOLD) : (y_s > U_ENTER);
    cand_c[ED] = e_q[ED] ? (y_s < D_HOLD) : (y_s < D_ENTER);
  end

  // Debounce, loss timer and LED mapping next-state.
  always_comb begin
    e_d        = e_q;
    p_d        = p_q;
    c_d        = c_q;
    lc_d       = lc_q;
    tracking_d = tracking_q;
    leds_d     = '0;
`ifdef XY_ZONE_TRACKER_LOST_BLINK_EN
    blink_d    = blink_q;
    seen_d     = seen_q;
`endif

    if (bus.valid) begin
      lc_d       = '0;
      tracking_d = 1'b1;
      if (cand_c == e_q) begin
        c_d = '0;
      end else if (cand_c == p_q) begin
        if (c_q == C_LAST) begin
          e_d = cand_c;
          c_d = '0;
        end else begin
          c_d = c_q + C_W'(1);
        end
      end else begin
        p_d = cand_c;
        c_d = C_W'(1);
        if (DEBOUNCE_N == 1) begin
          e_d = cand_c;
        end
      end
    end else begin
      if (lc_q != LC_MAX) begin
        lc_d = lc_q + LC_W'(1);
      end
      // Tracking drops on the edge at which LC reaches LOST_CYCLES-1.
      if (lc_q >= LC_LOSE) begin
        tracking_d = 1'b0;
        e_d        = '0;
        p_d        = '0;
        c_d        = '0;
      end
    end

`ifdef XY_ZONE_TRACKER_LOST_BLINK_EN
    seen_d = seen_q | bus.valid;
    if (bus.valid) begin
      blink_d = '0;
    end else if (!tracking_d && seen_q) begin
      blink_d = blink_q + BLINK_W'(1);
    end
`endif

    if (tracking_d) begin
      leds_d = {e_d[EL], e_d[ED], e_d[ER], e_d[EU], ~|e_d};
    end
`ifdef XY_ZONE_TRACKER_LOST_BLINK_EN
    else if (seen_d) begin
      leds_d = {4'b0000, blink_d[BLINK_W-1]};
    end
`endif
  end

  // State and output registers; async reset clears everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q        <= '0;
      p_q        <= '0;
      c_q        <= '0;
      lc_q       <= '0;
      tracking_q <= 1'b0;
      leds_q     <= '0;
`ifdef XY_ZONE_TRACKER_LOST_BLINK_EN
      blink_q    <= '0;
      seen_q     <= 1'b0;
`endif
    end else begin
      e_q        <= e_d;
      p_q        <= p_d;
      c_q        <= c_d;
      lc_q       <= lc_d;
      tracking_q <= tracking_d;
      leds_q     <= leds_d;
`ifdef XY_ZONE_TRACKER_LOST_BLINK_EN
      blink_q    <= blink_d;
      seen_q     <= seen_d;
`endif
    end
  end

  assign bus.leds     = leds_q;
  assign bus.tracking = tracking_q;

endmodule

// File: tb/tb_xy_zone_tracker.sv
// Scoreboard bench for xy_zone_tracker: two instances (DEBOUNCE_N = 1 and 3,
// LOST_CYCLES = 100) see identical stimulus; a zone model predicts each
// registered output and a monitor compares once per clock.
module tb_xy_zone_tracker;

  localparam int CW   = 11;
  localparam int MX   = 500;
  localparam int MY   = 500;
  localparam int CD   = 250;
  localparam int HY   = 16;
  localparam int LOST = 100;

  logic clk;
  logic reset;

  int checks = 0;
  int errors = 0;

  xy_zone_tracker_if #(.COORD_W(CW)) if1 ();
  xy_zone_tracker_if #(.COORD_W(CW)) if3 ();

  xy_zone_tracker #(
    .COORD_W(CW), .MID_X(MX), .MID_Y(MY), .CENT_D(CD), .HYST(HY),
    .DEBOUNCE_N(1), .LOST_CYCLES(LOST), .BLINK_LOG2(2)
  ) dut1 (
    .clk(clk), .reset(reset), .bus(if1)
  );

  xy_zone_tracker #(
    .COORD_W(CW), .MID_X(MX), .MID_Y(MY), .CENT_D(CD), .HYST(HY),
    .DEBOUNCE_N(3), .LOST_CYCLES(LOST), .BLINK_LOG2(2)
  ) dut3 (
    .clk(clk), .reset(reset), .bus(if3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: which display edges are committed, which change is
  // waiting, how many agreeing samples it has, and idle time since last sample.
  typedef struct {
    bit right, left, up, down;
    bit p_right, p_left, p_up, p_down;
    int agree;
    int idle;
    bit trk;
  } mstate_t;

  mstate_t m1, m3;
  logic [5:0] exp1_q[$];
  logic [5:0] exp3_q[$];

  function automatic mstate_t mreset();
    mstate_t s;
    s.right = 0; s.left = 0; s.up = 0; s.down = 0;
    s.p_right = 0; s.p_left = 0; s.p_up = 0; s.p_down = 0;
    s.agree = 0; s.idle = 0; s.trk = 0;
    return s;
  endfunction

  function automatic mstate_t step(input mstate_t s, input bit v,
                                   input int xv, input int yv, input int dn);
    mstate_t n;
    bit cr, cl, cu, cd;
    n = s;
    if (v) begin
      n.idle = 0;
      n.trk  = 1;
      // An edge already lit stays lit until the point retreats past the margin.
      cr = s.right ? (xv > MX + CD - HY) : (xv > MX + CD);
      cl = s.left  ? (xv < MX - CD + HY) : (xv < MX - CD);
      cu = s.up    ? (yv > MY + CD - HY) : (yv > MY + CD);
      cd = s.down  ? (yv < MY - CD + HY) : (yv < MY - CD);
      if (cr == s.right && cl == s.left && cu == s.up && cd == s.down) begin
        n.agree = 0;
      end else if (cr == s.p_right && cl == s.p_left && cu == s.p_up && cd == s.p_down) begin
        n.agree = s.agree + 1;
        if (n.agree >= dn) begin
          n.right = cr; n.left = cl; n.up = cu; n.down = cd;
          n.agree = 0;
        end
      end else begin
        n.p_right = cr; n.p_left = cl; n.p_up = cu; n.p_down = cd;
        n.agree = 1;
        if (dn == 1) begin
          n.right = cr; n.left = cl; n.up = cu; n.down = cd;
        end
      end
    end else begin
      n.idle = s.idle + 1;
      if (n.idle >= LOST - 1) begin
        n = mreset();
        n.idle = s.idle + 1;
      end
    end
    return n;
  endfunction

  // Expected {leds[4:0], tracking}.
  function automatic logic [5:0] expect_of(input mstate_t s);
    logic [4:0] l;
    l = 5'b00000;
    if (s.trk) begin
      if (s.up)    l[1] = 1'b1;
      if (s.right) l[2] = 1'b1;
      if (s.down)  l[3] = 1'b1;
      if (s.left)  l[4] = 1'b1;
      if (!(s.up || s.right || s.down || s.left)) l[0] = 1'b1;
    end
    return {l, s.trk};
  endfunction

  task automatic chk(input string nm, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got leds=%b tracking=%b, expected leds=%b tracking=%b",
               nm, got[5:1], got[0], exp[5:1], exp[0]);
    end
  endtask

  // Monitor: every clock edge is an output presentation; pop and compare.
  logic [5:0] e1, e3;
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      if (exp1_q.size() > 0) begin
        e1 = exp1_q.pop_front();
        chk("sb_dn1", {if1.leds, if1.tracking}, e1);
      end
      if (exp3_q.size() > 0) begin
        e3 = exp3_q.pop_front();
        chk("sb_dn3", {if3.leds, if3.tracking}, e3);
      end
    end
  end

  // Drive one clock of stimulus (called at a falling edge) and queue predictions.
  task automatic cycle(input bit v, input int xv, input int yv);
    if1.valid = v;  if1.x = CW'(xv);  if1.y = CW'(yv);
    if3.valid = v;  if3.x = CW'(xv);  if3.y = CW'(yv);
    m1 = step(m1, v, xv, yv, 1);
    m3 = step(m3, v, xv, yv, 3);
    exp1_q.push_back(expect_of(m1));
    exp3_q.push_back(expect_of(m3));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0);
  endtask

  // Assert reset between edges and confirm outputs clear without a clock.
  task automatic do_reset(input string nm);
    reset = 1'b1;
    #1;
    chk({nm, "_dn1"}, {if1.leds, if1.tracking}, 6'b000000);
    chk({nm, "_dn3"}, {if3.leds, if3.tracking}, 6'b000000);
    m1 = mreset();
    m3 = mreset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic int pick_coord();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 2047));
      1:       return int'($urandom_range(730, 770));
      2:       return int'($urandom_range(230, 270));
      default: return 500;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    if1.valid = 1'b0; if1.x = '0; if1.y = '0;
    if3.valid = 1'b0; if3.x = '0; if3.y = '0;
    m1 = mreset();
    m3 = mreset();
    @(negedge clk);
    do_reset("reset_state");

    // Centre sample lights centre and raises tracking on the next edge.
    cycle(1'b1, 500, 500);
    chk("centre_dn1", {if1.leds, if1.tracking}, 6'b000011);
    chk("centre_dn3", {if3.leds, if3.tracking}, 6'b000011);

    // Reset asserted mid-stream clears outputs asynchronously.
    @(posedge clk);
    @(negedge clk);
    do_reset("async_reset");

    // Debounce: two right samples interrupted by centre do not commit.
    cycle(1'b1, 800, 500);
    cycle(1'b1, 800, 500);
    cycle(1'b1, 500, 500);
    chk("deb_hold_dn3", {if3.leds, if3.tracking}, 6'b000011);
    cycle(1'b1, 800, 500);
    cycle(1'b1, 800, 500);
    chk("deb_2nd_dn3", {if3.leds, if3.tracking}, 6'b000011);
    cycle(1'b1, 800, 500);
    chk("deb_commit_dn3", {if3.leds, if3.tracking}, 6'b001001);

    // Hysteresis on the right edge (immediate commit instance).
    cycle(1'b1, 751, 500);
    chk("hyst_751", {if1.leds, if1.tracking}, 6'b001001);
    cycle(1'b1, 740, 500);
    chk("hyst_740", {if1.leds, if1.tracking}, 6'b001001);
    cycle(1'b1, 734, 500);
    chk("hyst_734", {if1.leds, if1.tracking}, 6'b000011);
    cycle(1'b1, 745, 500);
    chk("hyst_745", {if1.leds, if1.tracking}, 6'b000011);

    // Diagonal lights two edges; a point exactly on thresholds is centre.
    cycle(1'b1, 100, 900);
    chk("diag_up_left", {if1.leds, if1.tracking}, 6'b100101);
    cycle(1'b1, 750, 250);
    chk("boundary", {if1.leds, if1.tracking}, 6'b000011);

    // Loss: a sample followed by LOST-1 empty cycles drops tracking.
    cycle(1'b1, 800, 500);
    idle(LOST - 2);
    chk("loss_before", {if1.leds, if1.tracking}, 6'b001001);
    idle(1);
    chk("loss_dn1", {if1.leds, if1.tracking}, 6'b000000);
    chk("loss_dn3", {if3.leds, if3.tracking}, 6'b000000);

    // A sample on the timeout cycle keeps tracking.
    cycle(1'b1, 500, 500);
    idle(LOST - 2);
    cycle(1'b1, 500, 900);
    chk("timeout_valid", {if1.leds, if1.tracking}, 6'b000101);
    idle(3);

    // Randomised traffic near thresholds, with occasional long silences.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        idle(int'($urandom_range(LOST - 4, LOST + 4)));
      end else if ($urandom_range(0, 9) < 6) begin
        cycle(1'b1, pick_coord(), pick_coord());
      end else begin
        cycle(1'b0, pick_coord(), pick_coord());
      end
    end

    @(posedge clk);
    #2;
    checks++;
    if (exp1_q.size() != 0 || exp3_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d predictions left, expected 0/0",
               exp1_q.size(), exp3_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xy_zone_tracker.md
Name: xy_zone_tracker

Overview:
- Registered, parametrised successor to the combinational XY-to-LED zone indicator.
- Takes tracked-point coordinates from the camera/position path with a sample strobe and drives a 5-LED zone display.
- LED layout: 1 = up, 4 = left, 0 = centre, 2 = right, 3 = down.
- Adds per-edge hysteresis, N-sample debounce, loss-of-tracking timeout and a tracking flag, so the display does not chatter at zone boundaries.

Parameters:
- COORD_W, 11, coordinate width in bits (unsigned).
- MID_X, 500, centre X.
- MID_Y, 500, centre Y.
- CENT_D, 250, half-width of the centre box.
- HYST, 16, hysteresis margin in coordinate units. Constraints: 0 <= HYST < CENT_D; MID ± CENT_D within 0..2^COORD_W-1.
- DEBOUNCE_N, 3, consecutive agreeing valid samples required to commit a change (>= 1).
- LOST_CYCLES, 1000000, clk cycles without valid before tracking is declared lost (>= 2).
- BLINK_LOG2, 22, blink half-period = 2^BLINK_LOG2 cycles (used only with the optional feature).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- x, input, COORD_W, point X; sampled only when valid = 1.
- y, input, COORD_W, point Y; sampled only when valid = 1.
- valid, input, 1, single-cycle sample strobe.
- leds, output, 5, registered zone LEDs.
- tracking, output, 1, registered; 1 while samples arrive within LOST_CYCLES.

Behaviour:
- Reset (async, any time, including mid-debounce): all cleared to 0:
  - leds, tracking;
  - committed edge flags E[R,L,U,D];
  - pending vector P, debounce count C, loss counter LC, blink counter.
- Threshold arithmetic: localparams in COORD_W+2-bit signed. Comparisons are strictly greater / strictly less.
- Candidate edge flags (combinational, from current E):
  - R: E.R ? x > MID_X+CENT_D-HYST : x > MID_X+CENT_D
  - L: E.L ? x < MID_X-CENT_D+HYST : x < MID_X-CENT_D
  - U: E.U ? y > MID_Y+CENT_D-HYST : y > MID_Y+CENT_D
  - D: E.D ? y < MID_Y-CENT_D+HYST : y < MID_Y-CENT_D
  - cand = {R,L,U,D}
- Debounce, evaluated on each clk edge with valid = 1:
  - cand == E: C <= 0.
  - cand == P and C+1 == DEBOUNCE_N: E <= cand, C <= 0.
  - cand == P otherwise: C <= C+1.
  - cand != P: P <= cand; C <= 1. If DEBOUNCE_N == 1, E <= cand immediately.
- Cycles with valid = 0: E, P, C hold.
- Loss timer:
  - valid = 1: LC <= 0 and tracking <= 1, on the same edge.
  - Otherwise LC increments.
  - When LC == LOST_CYCLES-1 and valid = 0: tracking <= 0, E/P/C <= 0, LC saturates.
  - valid on the timeout cycle wins (tracking stays 1).
- LED mapping (registered, updated on the same edge as E/tracking):
  - leds[2] = E.R, leds[4] = E.L, leds[1] = E.U, leds[3] = E.D.
  - leds[0] = tracking & ~|E.
  - Diagonals light two edge LEDs.
  - A point exactly on a threshold lights centre (not an edge LED).
- Latency: with DEBOUNCE_N = 1, leds reflect the sample on the edge that captures valid; otherwise on the edge capturing the DEBOUNCE_N-th agreeing sample.
- Not tracking: leds = 0 (see optional feature).

Optional Feature:
- Macro: XY_ZONE_TRACKER_LOST_BLINK_EN.
- Defined: while tracking = 0 after at least one valid since reset, a free-running BLINK_LOG2+1-bit counter runs, leds[0] = counter MSB, and other LEDs stay 0. On reacquire, the counter clears and normal mapping resumes.
- Undefined: no counter is instantiated; leds = 0 whenever tracking = 0.
- Immediately after reset, leds = 0 in both builds.

Test Plan:
- Reset, then one valid at (500,500), DEBOUNCE_N=1 -> next edge leds=5'b00001, tracking=1. Assert reset mid-stream -> leds=0 and tracking=0 immediately (async).
- DEBOUNCE_N=3, valid samples at (800,500)x2 then (500,500) -> leds stay 5'b00001. Then (800,500)x3 -> leds=5'b00100 on the 3rd sample edge.
- Hysteresis, HYST=16, DEBOUNCE_N=1:
  - x=751 -> leds[2]=1;
  - x=740 -> leds[2] stays 1;
  - x=734 -> leds[2]=0, leds[0]=1;
  - x=745 -> leds[2] stays 0.
- Diagonal (100,900) with DEBOUNCE_N=1 -> leds=5'b10010. Boundary (750,250) -> leds=5'b00001.
- LOST_CYCLES=100: valid then 99 idle cycles -> tracking=0, leds=0. Valid coincident with the timeout cycle -> tracking stays 1.
- With XY_ZONE_TRACKER_LOST_BLINK_EN and BLINK_LOG2=2, after loss -> leds[0] toggles every 4 cycles. Next valid -> leds follow the mapping on that edge.
